// File: rtl/ami_cmd.sv
// AXI4 master command engine: one user command at a time, issued as a single full-width INCR burst.
// Optional build macro AMI_4KB_CHECK_EN rejects commands whose burst would cross a 4KB page.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for a command, cmd_ready=1
// AW    | write address presented, waiting for AWREADY
// W     | write beats streamed from u_w* to W channel
// B     | waiting for write response
// AR    | read address presented, waiting for ARREADY
// R     | read beats streamed from R channel to u_r*
module ami_cmd #(
   parameter int AXI_DW = 128,
   parameter int AXI_AW = 40,
   parameter int AXI_IW = 8,
   parameter int AXI_LW = 8,
   parameter int AXI_ID = 0
) (
   input  logic                  usr_clk,
   input  logic                  usr_reset_n,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [AXI_AW-1:0]     cmd_addr,
   input  logic [AXI_LW-1:0]     cmd_len,

   input  logic [AXI_DW-1:0]     u_wdata,
   input  logic [AXI_DW/8-1:0]   u_wstrb,
   input  logic                  u_wvalid,
   output logic                  u_wready,

   output logic [AXI_DW-1:0]     u_rdata,
   output logic                  u_rlast,
   output logic                  u_rvalid,
   input  logic                  u_rready,

   output logic                  done_valid,
   output logic                  done_write,
   output logic                  done_err,

   output logic [AXI_IW-1:0]     AWID,
   output logic [AXI_AW-1:0]     AWADDR,
   output logic [AXI_LW-1:0]     AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,

   output logic [AXI_DW-1:0]     WDATA,
   output logic [AXI_DW/8-1:0]   WSTRB,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,

   input  logic [AXI_IW-1:0]     BID,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,

   output logic [AXI_IW-1:0]     ARID,
   output logic [AXI_AW-1:0]     ARADDR,
   output logic [AXI_LW-1:0]     ARLEN,
   output logic [2:0]            ARSIZE,
   output logic [1:0]            ARBURST,
   output logic                  ARVALID,
   input  logic                  ARREADY,

   input  logic [AXI_IW-1:0]     RID,
   input  logic [AXI_DW-1:0]     RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
);

   localparam int BPB  = AXI_DW / 8;
   localparam int ALSB = $clog2(BPB);
   localparam logic [AXI_AW-1:0] ALIGN_MASK = ~((AXI_AW'(1) << ALSB) - AXI_AW'(1));

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [AXI_AW-1:0] addr_q;
   logic [AXI_LW-1:0] len_q;
   logic [AXI_LW:0]   cnt_q;
   logic              rerr_q;
   logic              done_valid_q;
   logic              done_write_q;
   logic              done_err_q;

   logic cmd_hs;
   logic reject;
   logic cnt_last;
   logic w_hs;
   logic b_hs;
   logic r_hs;
   logic r_end;
   logic r_beat_err;
   logic unused_inputs;

   assign cmd_hs     = cmd_valid && (state == S_IDLE);
   assign cnt_last   = (cnt_q == {1'b0, len_q});
   assign w_hs       = (state == S_W) && u_wvalid && WREADY;
   assign b_hs       = (state == S_B) && BVALID;
   assign r_hs       = (state == S_R) && RVALID && u_rready;
   // A burst ends on RLAST or on the expected final beat, whichever comes first
   assign r_end      = r_hs && (RLAST || cnt_last);
   assign r_beat_err = RRESP[1] || (RLAST != cnt_last);

`ifdef AMI_4KB_CHECK_EN
   logic [31:0] page_end;
   assign page_end = 32'(cmd_addr[11:0] & ALIGN_MASK[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BPB);
   assign reject   = (page_end > 32'd4096);
`else
   assign reject   = 1'b0;
`endif

   assign unused_inputs = ^{BID, RID, BRESP[0], RRESP[0]};

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cmd_hs && !reject) state_nxt = cmd_write ? S_AW : S_AR;
         S_AW:   if (AWREADY) state_nxt = S_W;
         S_W:    if (w_hs && cnt_last) state_nxt = S_B;
         S_B:    if (BVALID) state_nxt = S_IDLE;
         S_AR:   if (ARREADY) state_nxt = S_R;
         S_R:    if (r_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         state        <= S_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         rerr_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_write_q <= 1'b0;
         done_err_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         done_valid_q <= 1'b0;
         if (cmd_hs) begin
            addr_q <= cmd_addr & ALIGN_MASK;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            rerr_q <= 1'b0;
            if (reject) begin
               done_valid_q <= 1'b1;
               done_write_q <= cmd_write;
               done_err_q   <= 1'b1;
            end
         end
         if (w_hs || r_hs) cnt_q <= cnt_q + (AXI_LW+1)'(1);
         if (r_hs) rerr_q <= rerr_q || r_beat_err;
         if (b_hs) begin
            done_valid_q <= 1'b1;
            done_write_q <= 1'b1;
            done_err_q   <= BRESP[1];
         end
         if (r_end) begin
            done_valid_q <= 1'b1;
            done_write_q <= 1'b0;
            done_err_q   <= rerr_q || r_beat_err;
         end
      end
   end

   assign cmd_ready  = (state == S_IDLE);
   assign done_valid = done_valid_q;
   assign done_write = done_write_q;
   assign done_err   = done_err_q;

   assign AWID    = AXI_IW'(AXI_ID);
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = 3'(ALSB);
   assign AWBURST = 2'b01;
   assign AWVALID = (state == S_AW);

   assign WDATA    = u_wdata;
   assign WSTRB    = u_wstrb;
   assign WLAST    = (state == S_W) && cnt_last;
   assign WVALID   = (state == S_W) && u_wvalid;
   assign u_wready = (state == S_W) && WREADY;

   assign BREADY = (state == S_B);

   assign ARID    = AXI_IW'(AXI_ID);
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARSIZE  = 3'(ALSB);
   assign ARBURST = 2'b01;
   assign ARVALID = (state == S_AR);

   assign RREADY   = (state == S_R) && u_rready;
   assign u_rvalid = (state == S_R) && RVALID;
   assign u_rdata  = RDATA;
   assign u_rlast  = (state == S_R) && RLAST;

endmodule

// File: doc/ami_cmd.md
# ami_cmd

AXI4 master command engine: the initiator counterpart to the team's AXI slave interface. It takes one user command at a time (write or read, address, burst length), drives the AXI4 AW/W/B or AR/R channels as a single INCR burst at full bus width, and streams data between the user side and the bus. It is used by DMA-style user logic and by testbenches to drive the slave interface, and runs entirely in the usr_clk domain.

## Interface
- AXI_DW, 128, data bus width (power of two, ≥ 8)
- AXI_AW, 40, address width
- AXI_IW, 8, ID width
- AXI_LW, 8, AxLEN width
- AXI_ID, 0, constant ID driven on AWID/ARID
- usr_clk  in  1  clock, also the AXI clock
- usr_reset_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_AW  burst start address; low log2(AXI_DW/8) bits are ignored and forced to 0
- cmd_len  in  AXI_LW  beats minus one
- u_wdata / u_wstrb  in  AXI_DW / AXI_DW/8  write data stream
- u_wvalid / u_wready  in/out  1  write stream handshake
- u_rdata / u_rlast  out  AXI_DW / 1  read data stream
- u_rvalid / u_rready  out/in  1  read stream handshake
- done_valid  out  1  one-cycle completion pulse
- done_write / done_err  out  1 / 1  completed direction; error flag
- AW*: AWID, AWADDR, AWLEN, AWSIZE(3), AWBURST(2), AWVALID out, AWREADY in
- W*: WDATA, WSTRB, WLAST, WVALID out, WREADY in
- B*: BID, BRESP(2), BVALID in, BREADY out
- AR*: ARID, ARADDR, ARLEN, ARSIZE(3), ARBURST(2), ARVALID out, ARREADY in
- R*: RID, RDATA, RRESP(2), RLAST, RVALID in, RREADY out

## Operation
- FSM states: IDLE, AW, W, B, AR, R. Only one command is in flight; there are no outstanding transactions.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len/write and go to AW (write) or AR (read). A rejected command (see Configuration) goes straight to done.
- AW/AR: AxVALID=1 from registered state; AxADDR/AxLEN come from latched values, AxSIZE=log2(AXI_DW/8), AxBURST=2'b01. Hold until AxREADY, then go to W or R.
- W: combinational pass-through of WVALID=u_wvalid, u_wready=WREADY, WDATA/WSTRB = u_wdata/u_wstrb. The beat counter (AXI_LW+1 bits) counts handshakes. WLAST=1 when count==len. The last handshake moves the FSM to B.
- B: BREADY=1. On BVALID, done_err=BRESP[1] and the FSM goes to IDLE.
- R: combinational pass-through of u_rvalid=RVALID, RREADY=u_rready, u_rdata=RDATA, u_rlast=RLAST. A sticky error accumulates RRESP[1] across beats. If RLAST disagrees with the beat counter (early or missing), that also sets the error. The beat carrying RLAST, or the beat where count==len, ends the burst. The FSM then goes to IDLE.
- BID/RID are not checked. Only one ID is ever outstanding.
- done_valid pulses in the cycle after the final B/R handshake, with done_write/done_err valid in that same cycle. The FSM is already IDLE, so cmd_ready=1 in the same cycle.

## Timing
- Reset values: cmd_ready=1, all AXI VALID/READY outputs=0, u_wready=0, u_rvalid=0, done_valid=0, done_err=0, done_write=0, WLAST=0. AxADDR/AxLEN reset to 0.
- Command accepted at cycle T → AxVALID at T+1.
- Zero-wait write of len L: AW handshake at T+1, W beats T+2..T+2+L, BREADY from T+3+L; if BVALID is at T+3+L, done_valid is at T+4+L.
- Zero-wait read of len L: AR handshake at T+1, R beats T+2..T+2+L, done_valid at T+3+L.
- AxVALID and the payload stay stable until the handshake, per AXI4. WVALID never rises outside state W.
- Simultaneous BVALID and a new cmd_valid: the command is not accepted until IDLE (cmd_ready=0 in B).
- L=0: a single beat with WLAST=1 on the first beat. L=2^AXI_LW-1: the counter does not wrap.
- Reset mid-burst: all outputs return to their reset values asynchronously and the burst is abandoned. The connected slave is reset together with this block.

## Configuration
- AMI_4KB_CHECK_EN defined: at acceptance, if addr[11:0] + (len+1)*AXI_DW/8 > 4096, no AXI transfer is issued. done_valid pulses at T+1 with done_err=1 and done_write=cmd_write. The write stream is not consumed.
- Not defined: every command is issued as given. 4KB legality is the caller's responsibility.

## Test plan
- Write addr=0x100, len=3, always-ready slave, BRESP=0 → 4 W beats, WLAST on the 4th, done_valid at T+7 with err=0, done_write=1.
- Read addr=0x200, len=7, RREADY toggling every other cycle → 8 beats delivered in order, u_rlast on the 8th, done err=0.
- Write with AWREADY held low for 5 cycles, then BRESP=2'b10 → AWVALID/AWADDR stable throughout, done_err=1.
- Read len=3 with the slave asserting RLAST on beat 2 → burst ends, done_err=1, FSM IDLE.
- With AMI_4KB_CHECK_EN: write addr=0xFF0, len=1, DW=128 → no AWVALID, done at T+1 with err=1. Without the macro: AWVALID is issued.
- Reset asserted during the W phase of len=15 → WVALID=0 and done_valid=0 immediately; after release cmd_ready=1 and a fresh len=0 write completes.
